fixed_divider: RTL and testbench



---
 rtl/fixed_divider.sv | 133 +++++++++++++
 tb/tb_fixed_divider.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fixed_divider.sv
// Sequential signed Q1.FRAC divider: radix-2 restoring on magnitudes, then sign/saturation/div-by-zero fixup.
// Optional FIXED_DIVIDER_ROUND_EN: round half away from zero before saturation.
module fixed_divider #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic             sat,
    output logic             div_zero
);
    localparam int ITER = WIDTH + FRAC;
    localparam int NW   = WIDTH + FRAC + 1;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0]    LAST    = CW'(ITER - 1);
    localparam logic [NW-1:0]    LIM_POS = {{(NW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [NW-1:0]    LIM_NEG = {{(NW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_Q   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_Q   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, OUT} state_t;
    state_t state, state_nx;

    logic [CW-1:0]    cnt;
    logic             sign_q, dvd_neg, dz;
    logic [WIDTH:0]   dvs_mag;
    logic [ITER-1:0]  num_sh;
    logic [NW-1:0]    q_mag;
    logic [WIDTH:0]   rem;

    // Unsigned WIDTH-bit negation maps the most negative value to 2^(WIDTH-1) correctly.
    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    assign dvd_abs = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_abs = divisor[WIDTH-1]  ? -divisor  : divisor;

    logic [WIDTH+1:0] trial, diff;
    logic             ge;
    assign trial = {rem, num_sh[ITER-1]};
    assign diff  = trial - {1'b0, dvs_mag};
    assign ge    = trial >= {1'b0, dvs_mag};

    logic [NW-1:0]    q_fin;
    logic [WIDTH-1:0] q_lo, fix_quot;
    logic             fix_sat;

    always_comb begin
        q_fin = q_mag;
`ifdef FIXED_DIVIDER_ROUND_EN
        if ({rem, 1'b0} >= {1'b0, dvs_mag})
            q_fin = q_mag + {{(NW-1){1'b0}}, 1'b1};
`endif
        q_lo     = q_fin[WIDTH-1:0];
        fix_quot = sign_q ? -q_lo : q_lo;
        fix_sat  = 1'b0;
        if (dz) begin
            fix_quot = dvd_neg ? MIN_Q : MAX_Q;
            fix_sat  = 1'b1;
        end else if (!sign_q && q_fin > LIM_POS) begin
            fix_quot = MAX_Q;
            fix_sat  = 1'b1;
        end else if (sign_q && q_fin > LIM_NEG) begin
            fix_quot = MIN_Q;
            fix_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = CALC;
            CALC: if (cnt == LAST) state_nx = FIX;
            FIX:  state_nx = OUT;
            OUT:  if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            sign_q   <= 1'b0;
            dvd_neg  <= 1'b0;
            dz       <= 1'b0;
            dvs_mag  <= '0;
            num_sh   <= '0;
            q_mag    <= '0;
            rem      <= '0;
            quot     <= '0;
            sat      <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    cnt     <= '0;
                    sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    dvd_neg <= dividend[WIDTH-1];
                    dz      <= (divisor == '0);
                    dvs_mag <= {1'b0, dvs_abs};
                    num_sh  <= {dvd_abs, {FRAC{1'b0}}};
                    q_mag   <= '0;
                    rem     <= '0;
                end
                CALC: begin
                    cnt    <= cnt + 1'b1;
                    num_sh <= {num_sh[ITER-2:0], 1'b0};
                    q_mag  <= {q_mag[NW-2:0], ge};
                    rem    <= ge ? diff[WIDTH:0] : trial[WIDTH:0];
                end
                FIX: begin
                    quot     <= fix_quot;
                    sat      <= fix_sat;
                    div_zero <= dz;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_divider.sv
// Directed self-checking bench for fixed_divider at WIDTH=8, FRAC=7.
module tb_fixed_divider;
    localparam int W = 8;
    localparam int F = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quot;
    logic         sat;
    logic         div_zero;

    int n_cmp = 0;
    int n_err = 0;

    fixed_divider #(.WIDTH(W), .FRAC(F)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quot(quot), .sat(sat), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input int a, input int b,
                         input int eq, input int es, input int ez);
        int lat;
        dividend = a[W-1:0];
        divisor  = b[W-1:0];
        in_valid = 1'b1;
        chk({tag, ":in_ready"}, int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        dividend = 8'h5A;
        divisor  = 8'hA5;
        chk({tag, ":busy"}, int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, ":latency"}, lat, W + F + 1);
        chk({tag, ":quot"}, int'($signed(quot)), eq);
        chk({tag, ":sat"}, int'(sat), es);
        chk({tag, ":div_zero"}, int'(div_zero), ez);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ":release_ov"}, int'(out_valid), 0);
        chk({tag, ":release_rdy"}, int'(in_ready), 1);
    endtask

    initial begin
        int lat;
        int q_third;
        repeat (2) tick();
        rst = 1'b0;
        chk("reset:in_ready", int'(in_ready), 1);
        chk("reset:out_valid", int'(out_valid), 0);
        chk("reset:quot", int'(quot), 0);
        chk("reset:sat", int'(sat), 0);
        chk("reset:div_zero", int'(div_zero), 0);

`ifdef FIXED_DIVIDER_ROUND_EN
        q_third = 43;
`else
        q_third = 42;
`endif
        do_op("q_pos",   32,   64,  64, 0, 0);
        do_op("q_neg",  -32,   64, -64, 0, 0);
        do_op("third",    1,    3,  q_third, 0, 0);
        do_op("nthird",  -1,    3, -q_third, 0, 0);
        do_op("sat_pos", 64,   32,  127, 1, 0);
        do_op("sat_neg", -64,  32, -128, 1, 0);
        do_op("sat_mm", -128, -128, 127, 1, 0);
        do_op("min_ok",  -64,  64, -128, 0, 0);
        do_op("dz_pos",   5,    0,  127, 1, 1);
        do_op("dz_neg",  -5,    0, -128, 1, 1);
        do_op("dz_zero",  0,    0,  127, 1, 1);
        do_op("zero_n",   0,   -5,    0, 0, 0);

        // backpressure with an ignored in_valid pulse during CALC
        dividend = 8'd32;
        divisor  = 8'd64;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        dividend = 8'd5;
        divisor  = 8'd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp:ignored_rdy", int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("bp:out_valid", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp:hold_quot", int'($signed(quot)), 64);
            chk("bp:hold_dz", int'(div_zero), 0);
            chk("bp:hold_rdy", int'(in_ready), 0);
            chk("bp:hold_ov", int'(out_valid), 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp:release_ov", int'(out_valid), 0);
        chk("bp:release_rdy", int'(in_ready), 1);
        repeat (3) tick();
        chk("bp:no_queue", int'(out_valid), 0);

        // reset in CALC iteration 8
        dividend = 8'd32;
        divisor  = 8'd64;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid:in_ready", int'(in_ready), 1);
        chk("rst_mid:out_valid", int'(out_valid), 0);
        chk("rst_mid:quot", int'(quot), 0);
        chk("rst_mid:sat", int'(sat), 0);
        do_op("after_rst", 32, 64, 64, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
